// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm drive block and its measurement front end:
// counter width default, FSM encodings and the bridge leg mapping.
package pwm_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } meas_state_e;

  // pwm's direct=1 switches MA[0]; direct=0 switches MA[1].
  localparam int LEG_FWD = 0;
  localparam int LEG_REV = 1;

  function automatic logic leg_to_dir(input logic leg);
    return (leg == LEG_FWD[0]);
  endfunction

endpackage

// File: rtl/pwm_meas_if.sv
// Measurement bus between pwm_meas (master) and its consumer (slave).
// Handshake: meas_vld is a one-cycle pulse with no ready; the consumer must
// capture period/high_time/dir/stall/stall_lvl in that cycle. Values hold otherwise.
interface pwm_meas_if #(parameter int CNT_W = 16) ();
  import pwm_pkg::*;

  logic             enable;
  logic [1:0]       ma_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             dir;
  logic             meas_vld;
  logic             stall;
  logic             stall_lvl;
  logic             fault;
  meas_state_e      state;

  modport master (
    input  enable, ma_in,
    output period, high_time, dir, meas_vld, stall, stall_lvl, fault, state
  );

  modport slave (
    output enable, ma_in,
    input  period, high_time, dir, meas_vld, stall, stall_lvl, fault, state
  );

endinterface

// File: rtl/pwm_meas_sync_edge.sv
// Two-flop synchronizer plus an edge register for one bridge leg;
// lvl_o is the synchronized level, rise_o/fall_o are one-cycle edge strobes.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_meas.sv
// PWM measurement front end for the H-bridge pair: recovers direction,
// measures period/high time, and flags stall and shoot-through.
module pwm_meas
  import pwm_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  pwm_meas_if.master  bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_V = TIMEOUT_CYC[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] lvl, rise, fall;

  sync_edge u_sync0 (
    .clk_i (sclk), .rst_ni (s_rst_n), .d_i (bus.ma_in[0]),
    .lvl_o (lvl[0]), .rise_o (rise[0]), .fall_o (fall[0])
  );

  sync_edge u_sync1 (
    .clk_i (sclk), .rst_ni (s_rst_n), .d_i (bus.ma_in[1]),
    .lvl_o (lvl[1]), .rise_o (rise[1]), .fall_o (fall[1])
  );

  meas_state_e      state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, hi_q;
  logic [CNT_W-1:0] period_q, high_q;
  logic             act_q, dir_q, vld_q, stall_q, stall_lvl_q, fault_q;
  logic             shoot;

  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
  assign shoot = (&lvl) | (&rise);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      act_q       <= LEG_REV[0];
      period_q    <= '0;
      high_q      <= '0;
      dir_q       <= 1'b0;
      vld_q       <= 1'b0;
      stall_q     <= 1'b0;
      stall_lvl_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (!bus.enable) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        fault_q <= 1'b0;
      end else if (shoot) begin
        // Abort whatever was in flight; no measurement is reported.
        fault_q <= 1'b1;
        state_q <= ST_WAIT_RISE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_WAIT_RISE;
            cnt_q   <= '0;
          end
          ST_WAIT_RISE: begin
            if (rise[0] ^ rise[1]) begin
              act_q   <= rise[1];
              cnt_q   <= CNT_ONE;
              state_q <= ST_MEASURE;
            end else if (cnt_q == TIMEOUT_V) begin
              // Still static after a stall: keep reporting once per timeout.
              period_q    <= '0;
              high_q      <= '0;
              stall_q     <= 1'b1;
              stall_lvl_q <= lvl[act_q];
              vld_q       <= 1'b1;
              cnt_q       <= CNT_ONE;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          ST_MEASURE: begin
            if (rise[act_q]) begin
              period_q <= cnt_q;
              high_q   <= hi_q;
              dir_q    <= leg_to_dir(act_q);
              stall_q  <= 1'b0;
              vld_q    <= 1'b1;
              cnt_q    <= CNT_ONE;
            end else if (rise[~act_q]) begin
              act_q <= ~act_q;
              cnt_q <= CNT_ONE;
            end else if (cnt_q == TIMEOUT_V) begin
              period_q    <= '0;
              high_q      <= '0;
              stall_q     <= 1'b1;
              stall_lvl_q <= lvl[act_q];
              vld_q       <= 1'b1;
              cnt_q       <= CNT_ONE;
              state_q     <= ST_WAIT_RISE;
            end else begin
              cnt_q <= cnt_d;
              if (fall[act_q]) hi_q <= cnt_q;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.dir       = dir_q;
  assign bus.meas_vld  = vld_q;
  assign bus.stall     = stall_q;
  assign bus.stall_lvl = stall_lvl_q;
  assign bus.fault     = fault_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas: expected measurements are queued as stimulus
// is driven and popped when meas_vld pulses.
module tb_pwm_meas;
  import pwm_pkg::*;

  localparam int W     = 16;
  localparam int TMO   = 1000;
  localparam int EXP_W = 2 * W + 3;

  // ---------------- clock / reset ----------------
  logic sclk = 1'b0;
  logic s_rst_n;
  always #5 sclk = ~sclk;

  logic [1:0] ma;
  logic       en;

  pwm_meas_if #(.CNT_W(W)) mif ();
  assign mif.ma_in  = ma;
  assign mif.enable = en;

  pwm_meas #(.CNT_W(W), .TIMEOUT_CYC(TMO)) dut (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .bus     (mif.master)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_obs, mon_exp;
  int total = 0;
  int bad   = 0;
  logic m_dir = 1'b0;
  logic m_lvl = 1'b0;

  function automatic logic [EXP_W-1:0] pack_exp(input logic st, input logic lv, input logic d,
                                                 input logic [W-1:0] per, input logic [W-1:0] hi);
    return {st, lv, d, per, hi};
  endfunction

  always @(negedge sclk) begin
    if (s_rst_n === 1'b1 && mif.meas_vld === 1'b1) begin
      mon_obs = {mif.stall, mif.stall_lvl, mif.dir, mif.period, mif.high_time};
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_vld observed=%h expected=none", mon_obs);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        total++;
        assert (mon_obs === mon_exp) else begin
          bad++;
          $error("FAIL meas observed=%h expected=%h", mon_obs, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL %s_missing_vld observed=%0d expected=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pwm_run(input int leg, input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      ma[leg] = 1'b1;
      if (k > 0) begin
        m_dir = (leg == 0);
        exp_q.push_back(pack_exp(1'b0, m_lvl, m_dir, W'(per), W'(hi)));
      end
      cyc(hi);
      ma[leg] = 1'b0;
      cyc(per - hi);
    end
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_period"}, mif.period, '0);
    chk({tag, "_high"},   mif.high_time, '0);
    chk({tag, "_dir"},    W'(mif.dir), '0);
    chk({tag, "_vld"},    W'(mif.meas_vld), '0);
    chk({tag, "_stall"},  W'(mif.stall), '0);
    chk({tag, "_lvl"},    W'(mif.stall_lvl), '0);
    chk({tag, "_fault"},  W'(mif.fault), '0);
    chk({tag, "_state"},  W'(mif.state), W'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ma = 2'b00;
    en = 1'b0;
    s_rst_n = 1'b0;
    cyc(3);
    chk_all_reset("rst");

    s_rst_n = 1'b1;
    cyc(2);
    en = 1'b1;
    cyc(3);
    chk("en_state", W'(mif.state), W'(ST_WAIT_RISE));

    // forward: MA[0] period 100, high 30
    pwm_run(0, 100, 30, 5);
    drain("fwd", 10);

    // reverse: MA[1] period 200, high 150; switch rise is discarded
    pwm_run(1, 200, 150, 4);
    drain("rev", 10);
    chk("rev_dir", W'(mif.dir), '0);

    // stall at 100 % duty on MA[0], reported twice
    ma = 2'b01;
    m_lvl = 1'b1;
    exp_q.push_back(pack_exp(1'b1, 1'b1, m_dir, '0, '0));
    exp_q.push_back(pack_exp(1'b1, 1'b1, m_dir, '0, '0));
    drain("stall", 2300);
    chk("stall_period", mif.period, '0);
    chk("stall_high",   mif.high_time, '0);
    chk("stall_flag",   W'(mif.stall), W'(1));
    chk("stall_lvl",    W'(mif.stall_lvl), W'(1));

    // shoot-through, then normal PWM: fault stays sticky
    ma = 2'b11;
    cyc(5);
    chk("shoot_fault", W'(mif.fault), W'(1));
    ma = 2'b00;
    cyc(5);
    pwm_run(0, 100, 30, 3);
    drain("post_fault", 10);
    chk("fault_sticky", W'(mif.fault), W'(1));
    chk("post_fault_dir", W'(mif.dir), W'(1));
    en = 1'b0;
    cyc(2);
    chk("fault_clear", W'(mif.fault), '0);
    chk("dis_state", W'(mif.state), W'(ST_IDLE));
    chk("dis_hold_period", mif.period, W'(100));

    // enable dropped at count 40: no pulse, outputs hold
    en = 1'b1;
    cyc(2);
    ma[0] = 1'b1; cyc(30); ma[0] = 1'b0; cyc(70);
    ma[0] = 1'b1;
    exp_q.push_back(pack_exp(1'b0, m_lvl, 1'b1, W'(100), W'(30)));
    cyc(30); ma[0] = 1'b0; cyc(10);
    en = 1'b0;
    cyc(60);
    ma[0] = 1'b1; cyc(30); ma[0] = 1'b0; cyc(70);
    drain("en_drop", 5);
    chk("en_drop_period", mif.period, W'(100));
    chk("en_drop_high",   mif.high_time, W'(30));
    chk("en_drop_state",  W'(mif.state), W'(ST_IDLE));

    // reset mid-period: outputs clear without a clock edge
    en = 1'b1;
    cyc(2);
    pwm_run(0, 100, 30, 2);
    ma[0] = 1'b1;
    exp_q.push_back(pack_exp(1'b0, m_lvl, 1'b1, W'(100), W'(100 - 70 + 0)));
    cyc(30); ma[0] = 1'b0; cyc(20);
    drain("pre_rst", 5);
    chk("pre_rst_period", mif.period, W'(100));
    s_rst_n = 1'b0;
    #1;
    chk_all_reset("async_rst");
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_meas.md
# pwm_meas

Measurement front end for the H-bridge motor drive pair `MA[1:0]` produced by the team's `pwm` block. It is the receive end of that interface:
- recovers drive direction from which leg is switching;
- measures PWM period and high time in `sclk` cycles;
- flags a stalled output or shoot-through (both legs high).

It sits beside the `pwm` instance, either as a loop-back self-check or as a readback source for a status register.

## Interface
- `CNT_W`, 16 — width of period/high-time counters and outputs.
- `TIMEOUT_CYC`, 50000 — cycles without a rising edge before stall is declared (1 ms at 50 MHz); must be < 2^CNT_W.
- `sclk` input 1 — system clock, 50 MHz nominal.
- `s_rst_n` input 1 — asynchronous active-low reset.
- `enable` input 1 — measurement enable; low forces IDLE and clears `fault`.
- `ma_in` input 2 — monitored bridge legs, asynchronous to `sclk`.
- `period` output CNT_W — cycles between consecutive rising edges of the active leg.
- `high_time` output CNT_W — cycles the active leg was high within that period.
- `dir` output 1 — 1 when `ma_in[0]` is the switching leg, 0 when `ma_in[1]`.
- `meas_vld` output 1 — single-cycle pulse; outputs updated this cycle.
- `stall` output 1 — qualifies `meas_vld`: static leg, no PWM edges.
- `stall_lvl` output 1 — level of the active leg when the stall was declared (0 = 0 % duty, 1 = 100 % duty).
- `fault` output 1 — sticky shoot-through flag.

## Operation
- Each `ma_in` bit passes through a 2-FF synchronizer and a third register.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- FSM states are IDLE, WAIT_RISE, MEASURE.
  - IDLE: entered on reset or when `enable`=0 (takes priority over everything). `enable`=1 moves to WAIT_RISE next cycle.
  - WAIT_RISE: on a rise of exactly one leg, record that leg as active, set `cnt`=1, go to MEASURE.
  - MEASURE: `cnt` increments every cycle and saturates at all-ones.
    - Fall of the active leg: latch `hi_cnt`=`cnt`.
    - Next rise of the active leg: load `period`=`cnt`, `high_time`=`hi_cnt`, `dir`, `stall`=0, pulse `meas_vld`, restart `cnt`=1. Stay in MEASURE.
    - Rise on the other leg: direction change. Discard the measurement with no `meas_vld`, switch the active leg, set `cnt`=1.
    - `cnt` reaches `TIMEOUT_CYC`: load `period`=0, `high_time`=0, `stall`=1, `stall_lvl`=synced active-leg level, `dir` unchanged. Pulse `meas_vld`, go to WAIT_RISE.
- Fault:
  - Both synced legs high, or both rise in the same cycle, sets `fault`=1.
  - Any measurement in progress is aborted without `meas_vld`, and the FSM returns to WAIT_RISE.
  - `fault` clears only while `enable`=0 or under reset.
- A rise and a fall of the active leg in the same cycle cannot occur; glitches shorter than one cycle may be lost in synchronization.
- Outputs hold their last values between `meas_vld` pulses and across IDLE.

## Timing
- All state is updated on the rising edge of `sclk`; reset is asynchronous.
- Reset values:
  - `period`=0, `high_time`=0, `dir`=0;
  - `meas_vld`=0, `stall`=0, `stall_lvl`=0, `fault`=0;
  - FSM=IDLE, `cnt`=0.
- Latency: `meas_vld` is asserted 3 `sclk` edges after the input rising edge (2 synchronizer stages + edge register).
- Precision: `period` equals the pin period in cycles exactly; `high_time` equals the high width exactly (±1 for an asynchronous input).
- The first `meas_vld` after WAIT_RISE needs two rises of the active leg.
- `enable` deasserted mid-measurement: IDLE on the next edge, no `meas_vld`, partial count dropped.
- Reset mid-measurement: all outputs return to their reset values immediately.

## Structure
- Shared package/include `pwm_pkg`:
  - `CNT_W` default;
  - FSM state encodings (IDLE=0, WAIT_RISE=1, MEASURE=2);
  - leg index constants matching `pwm`'s `direct` mapping (`direct`=1 ↔ `MA[0]` switching).
- One sub-module `sync_edge`: 2-FF sync + edge register, outputs `lvl`, `rise`, `fall`. Instantiated once per leg.

## Test plan
- Forward PWM: `ma_in[0]` period 100, high 30, `ma_in[1]`=0. Required from the 2nd rise onward: `meas_vld` each period with `period`=100, `high_time`=30, `dir`=1, `stall`=0.
- Reverse PWM: `ma_in[1]` period 200, high 150. Required: `period`=200, `high_time`=150, `dir`=0. The first measurement after switching from forward is discarded (no `meas_vld` on the switch).
- Stall: hold `ma_in`=2'b01 with `TIMEOUT_CYC`=1000. Required: `meas_vld` with `stall`=1, `stall_lvl`=1, `period`=0, `high_time`=0; repeats every 1000 cycles while held.
- Shoot-through: drive `ma_in`=2'b11 for 5 cycles. Required: `fault`=1 stays set after the legs return to normal PWM; it clears only after `enable` is pulsed low.
- Enable/reset mid-measurement:
  - Drop `enable` at count 40 of a period-100 waveform: no `meas_vld`, outputs hold.
  - Assert `s_rst_n`=0 mid-period: all outputs 0 asynchronously.
